// File: rtl/sw_bt_regs.sv
// Purpose : register front-end for the conditioned switch/button word (DATA, EDGE, IRQ_EN, COUNT) with a level irq.
// Latency : reads return rdata/rvalid one cycle after re; irq follows edge detection or clear by one cycle.
// Backpressure : none; every re and we is accepted in its own cycle, and rvalid is a single-cycle pulse.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   sw_bt_in[31:0]    conditioned word: [15:0] switches, [19:16] buttons, [31:20] zero
//   we, re            single-cycle write/read strobes
//   addr[ADDR_W-1:0]  byte address (bits [1:0] ignored); wdata[31:0] write data
//   rdata[31:0]       registered read data, holds between reads; rvalid one-cycle read strobe
//   irq               level interrupt
//
// Optional feature macro: SW_CHANGE_IRQ_EN adds SWCHG at 0x10 (switch change flags) and IRQ_EN bit 4.
module sw_bt_regs #(
`ifdef SW_CHANGE_IRQ_EN
    parameter int ADDR_W = 5,
`else
    parameter int ADDR_W = 4,
`endif
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       sw_bt_in,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              irq
);

    localparam int IDX_W = ADDR_W - 2;
`ifdef SW_CHANGE_IRQ_EN
    localparam int EN_W = 5;
`else
    localparam int EN_W = 4;
`endif

    logic [IDX_W-1:0] widx;
    logic [3:0]       prev_bt;
    logic             armed;
    logic [3:0]       edge_q, edge_next, rise, clr_edge;
    logic [EN_W-1:0]  irq_en_q, irq_en_next;
    logic [CNT_W-1:0] count_q;
    logic [2:0]       rise_cnt;
    logic             irq_next;
    logic [31:0]      rd_mux;

    assign widx = addr[ADDR_W-1:2];

    // armed stays low for the first edge after reset so buttons held
    // through reset load prev_bt without registering a press.
    assign rise     = armed ? (sw_bt_in[19:16] & ~prev_bt) : 4'b0;
    assign rise_cnt = {2'b0, rise[0]} + {2'b0, rise[1]} + {2'b0, rise[2]} + {2'b0, rise[3]};

    assign clr_edge  = (we && widx == IDX_W'(1)) ? wdata[3:0] : 4'b0;
    // A fresh edge is OR'd in after the clear, so it survives a same-cycle W1C.
    assign edge_next = (edge_q & ~clr_edge) | rise;

    assign irq_en_next = (we && widx == IDX_W'(2)) ? wdata[EN_W-1:0] : irq_en_q;

`ifdef SW_CHANGE_IRQ_EN
    logic [15:0] prev_sw, swchg_q, swchg_next, sw_chg, clr_sw;

    assign sw_chg     = armed ? (sw_bt_in[15:0] ^ prev_sw) : 16'b0;
    assign clr_sw     = (we && widx == IDX_W'(4)) ? wdata[15:0] : 16'b0;
    assign swchg_next = (swchg_q & ~clr_sw) | sw_chg;
    assign irq_next   = (|(edge_next & irq_en_next[3:0])) | (irq_en_next[4] & (|swchg_next));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sw <= 16'b0;
            swchg_q <= 16'b0;
        end else begin
            prev_sw <= sw_bt_in[15:0];
            swchg_q <= swchg_next;
        end
    end
`else
    assign irq_next = |(edge_next & irq_en_next);
`endif

    // Read mux sees pre-write register values; unmapped offsets read 0.
    always_comb begin
        rd_mux = 32'b0;
        if (widx == IDX_W'(0)) begin
            rd_mux = sw_bt_in;
        end else if (widx == IDX_W'(1)) begin
            rd_mux = {28'b0, edge_q};
        end else if (widx == IDX_W'(2)) begin
            rd_mux = {{(32-EN_W){1'b0}}, irq_en_q};
        end else if (widx == IDX_W'(3)) begin
            rd_mux = 32'(count_q);
`ifdef SW_CHANGE_IRQ_EN
        end else if (widx == IDX_W'(4)) begin
            rd_mux = {16'b0, swchg_q};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_bt  <= 4'b0;
            armed    <= 1'b0;
            edge_q   <= 4'b0;
            irq_en_q <= '0;
            count_q  <= '0;
            irq      <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= 32'b0;
        end else begin
            prev_bt  <= sw_bt_in[19:16];
            armed    <= 1'b1;
            edge_q   <= edge_next;
            irq_en_q <= irq_en_next;
            count_q  <= count_q + CNT_W'(rise_cnt);
            irq      <= irq_next;
            rvalid   <= re;
            if (re) begin
                rdata <= rd_mux;
            end
        end
    end

    // Bits that carry no meaning in this map.
    logic unused_bits;
    assign unused_bits = &{1'b0, wdata[31:EN_W], addr[1:0]};

endmodule

// File: tb/tb_sw_bt_regs.sv
module tb_sw_bt_regs;

    logic        clk;
    logic        rst_n;
    logic [31:0] sw_bt_in;
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        irq;

    sw_bt_regs dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sw_bt_in (sw_bt_in),
        .we       (we),
        .re       (re),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] dat;
        logic        irq;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: plain flags and integers.
    bit   m_flag [4];
    bit   m_en   [4];
    bit   m_held [4];
    bit   m_live;
    int   m_count;
    logic [31:0] m_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_reg(input int idx, input logic [31:0] live);
        logic [31:0] v;
        v = 32'h0;
        case (idx)
            0: v = live;
            1: for (int i = 0; i < 4; i++) v[i] = m_flag[i];
            2: for (int i = 0; i < 4; i++) v[i] = m_en[i];
            3: v = 32'(m_count);
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // One bus cycle: drive at a negedge, predict what the next posedge produces.
    task automatic step(input logic [31:0] in, input logic w, input logic r,
                        input logic [3:0] a, input logic [31:0] d);
        exp_t e;
        int   idx;
        bit   pressed;
        bit   any_irq;
        sw_bt_in = in; we = w; re = r; addr = a; wdata = d;
        idx = int'(a[3:2]);
        if (r) m_rdata = m_reg(idx, in);
        if (w && idx == 1)
            for (int i = 0; i < 4; i++) if (d[i]) m_flag[i] = 0;
        for (int i = 0; i < 4; i++) begin
            pressed = in[16+i];
            if (m_live && pressed && !m_held[i]) begin
                m_flag[i] = 1;
                m_count   = (m_count + 1) % 65536;
            end
            m_held[i] = pressed;
        end
        if (w && idx == 2)
            for (int i = 0; i < 4; i++) m_en[i] = d[i];
        m_live = 1;
        any_irq = 0;
        for (int i = 0; i < 4; i++) if (m_flag[i] && m_en[i]) any_irq = 1;
        e.vld = r; e.dat = m_rdata; e.irq = any_irq;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] in);
        step(in, 1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic rd(input logic [31:0] in, input logic [3:0] a);
        step(in, 1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic wr(input logic [31:0] in, input logic [3:0] a, input logic [31:0] d);
        step(in, 1'b1, 1'b0, a, d);
    endtask

    // Called at a negedge; asserts reset away from any posedge.
    task automatic do_reset(input logic [31:0] in, input bit check_now);
        sw_bt_in = in; we = 0; re = 0; rst_n = 0;
        #1;
        if (check_now) begin
            chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
            chk("rst_rdata", rdata, 32'h0);
            chk("rst_irq", {31'b0, irq}, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            m_flag[i] = 0; m_en[i] = 0; m_held[i] = 0;
        end
        m_live = 0; m_count = 0; m_rdata = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    // Monitor: compare the DUT outputs one step after each posedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rvalid", {31'b0, rvalid}, {31'b0, e.vld});
                chk("rdata", rdata, e.dat);
                chk("irq", {31'b0, irq}, {31'b0, e.irq});
            end
        end
    end

    initial begin
        logic [31:0] r1, r2, r3;
        clk = 0; rst_n = 0; sw_bt_in = 0; we = 0; re = 0; addr = 0; wdata = 0;
        @(negedge clk);

        // Buttons held through reset give no edge.
        do_reset(32'h000F_0000, 1'b0);
        rd(32'h000F_0000, 4'h4);
        rd(32'h000F_0000, 4'hC);
        rd(32'h000F_0000, 4'h0);
        idle(32'h000F_0000);

        // Single button pulse, irq enable, W1C clear.
        idle(32'h0000_A5A5);
        wr(32'h0000_A5A5, 4'h8, 32'h1);
        repeat (3) idle(32'h0001_A5A5);
        idle(32'h0000_A5A5);
        rd(32'h0000_A5A5, 4'h4);
        rd(32'h0000_A5A5, 4'hC);
        wr(32'h0000_A5A5, 4'h4, 32'h1);
        idle(32'h0000_A5A5);
        rd(32'h0000_A5A5, 4'h4);

        // Two buttons rise together.
        idle(32'h000A_0000);
        rd(32'h000A_0000, 4'h4);
        rd(32'h000A_0000, 4'hC);

        // New edge beats same-cycle clear; read+write same cycle returns old value.
        wr(32'h0, 4'h4, 32'hF);
        wr(32'h0004_0000, 4'h4, 32'h4);
        step(32'h0004_0000, 1'b1, 1'b1, 4'h8, 32'hFFFF_FFF5);
        rd(32'h0004_0000, 4'h8);
        step(32'h0004_0000, 1'b1, 1'b1, 4'hC, 32'h1234);
        rd(32'h0004_0000, 4'h4);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            r1 = $urandom; r2 = $urandom; r3 = $urandom;
            step({12'h0, r1[19:0]}, r2[0], r2[1], r2[7:4], r3);
            if (r2[13:8] == 0) rd({12'h0, r1[19:0]}, 4'hC);
        end

        // Async reset while a read response and irq are live.
        wr(32'h0, 4'h8, 32'h3);
        idle(32'h0003_0000);
        idle(32'h0);
        rd(32'h0, 4'h4);
        do_reset(32'h0, 1'b1);
        rd(32'h0, 4'h4);
        rd(32'h0, 4'h8);
        rd(32'h0, 4'hC);

        // Counter wrap: 65532 four-button presses, 3 more, then one to wrap.
        for (int n = 0; n < 16383; n++) begin
            idle(32'h000F_0000);
            idle(32'h0);
        end
        idle(32'h0007_0000);
        idle(32'h0);
        rd(32'h0, 4'hC);
        idle(32'h0001_0000);
        idle(32'h0);
        rd(32'h0, 4'hC);
        wr(32'h0, 4'hC, 32'h1234);
        rd(32'h0, 4'hC);
        idle(32'h0);

        @(posedge clk);
        #2;
        chk("drain", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
